cursor_overlay: RTL and testbench



---
 rtl/cursor_overlay.sv | 150 +++++++++++++++
 tb/tb_cursor_overlay.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cursor_overlay.sv
// Hardware cursor overlay: blends a 16x16 one-bit cursor with optional blink
// onto the CLUT pixel stream, with a fixed one-cycle latency on RGB and syncs.
module cursor_overlay #(
    parameter int CURSOR_SIZE = 16,
    parameter int BLINK_UNIT  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_adr,
    input  logic [23:0] register_data,
    input  logic        register_write,
    input  logic [8:0]  video_x,
    input  logic [8:0]  video_y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync
);

    localparam int                IDX_W  = $clog2(CURSOR_SIZE);
    localparam logic [9:0]        SIZE10 = 10'(CURSOR_SIZE);
    localparam logic [IDX_W-1:0]  LAST   = IDX_W'(CURSOR_SIZE - 1);
    localparam logic [5:0]        UNIT6  = 6'(BLINK_UNIT);

    typedef enum logic {ST_ON, ST_OFF} blink_t;

    logic [CURSOR_SIZE-1:0] r_pattern [CURSOR_SIZE];
    logic [9:0]             r_cur_x, r_cur_y;
    logic                   r_enable, r_blink_type;
    logic [2:0]             r_on_period, r_off_period;
    logic [3:0]             r_colour;
    blink_t                 r_state, w_state_nx;
    logic [5:0]             r_cnt, w_cnt_nx;
    logic                   r_vsync_q;

    logic                   w_ctrl_wr, w_tick;
    logic [9:0]             w_dx, w_dy;
    logic                   w_inside, w_bit, w_hit;
    logic [CURSOR_SIZE-1:0] w_row;
    logic [5:0]             w_limit, w_cnt_inc;

    function automatic logic [7:0] cursor_chan(input logic on, input logic inten);
        return on ? (inten ? 8'hFF : 8'h80) : 8'h00;
    endfunction

    assign w_ctrl_wr = register_write && (register_adr == 7'h4e);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CURSOR_SIZE; i++) r_pattern[i] <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_enable     <= 1'b0;
            r_blink_type <= 1'b0;
            r_on_period  <= '0;
            r_off_period <= '0;
            r_colour     <= '0;
        end else if (register_write) begin
            case (register_adr)
                7'h4d: begin
                    r_cur_x <= register_data[9:0];
                    r_cur_y <= register_data[21:12];
                end
                7'h4e: begin
                    r_enable     <= register_data[23];
                    r_blink_type <= register_data[22];
                    r_on_period  <= register_data[21:19];
                    r_off_period <= register_data[18:16];
                    r_colour     <= register_data[3:0];
                end
                7'h4f: r_pattern[register_data[16 +: IDX_W]] <= register_data[CURSOR_SIZE-1:0];
                default: ;
            endcase
        end
    end

    // Unsigned wrap turns pixels left of / above the cursor into large offsets.
    assign w_dx     = {1'b0, video_x} - r_cur_x;
    assign w_dy     = {1'b0, video_y} - r_cur_y;
    assign w_inside = (w_dx < SIZE10) && (w_dy < SIZE10);
    assign w_row    = r_pattern[w_dy[IDX_W-1:0]];
    assign w_bit    = w_row[LAST - w_dx[IDX_W-1:0]];
    assign w_hit    = r_enable && w_inside && w_bit;

    assign w_tick    = vsync_in && !r_vsync_q;
    assign w_cnt_inc = r_cnt + 6'd1;
    assign w_limit   = (r_state == ST_ON) ? (6'(r_on_period) * UNIT6)
                                          : (6'(r_off_period) * UNIT6);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_ON;
            r_cnt     <= '0;
            r_vsync_q <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_vsync_q <= vsync_in;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (w_ctrl_wr || r_on_period == 3'd0 || r_off_period == 3'd0) begin
            w_state_nx = ST_ON;
            w_cnt_nx   = '0;
        end else if (w_tick) begin
            if (w_cnt_inc == w_limit) begin
                w_state_nx = (r_state == ST_ON) ? ST_OFF : ST_ON;
                w_cnt_nx   = '0;
            end else begin
                w_cnt_nx   = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            hsync <= hsync_in;
            vsync <= vsync_in;
            if (w_hit && r_state == ST_ON) begin
                r <= cursor_chan(r_colour[3], r_colour[0]);
                g <= cursor_chan(r_colour[2], r_colour[0]);
                b <= cursor_chan(r_colour[1], r_colour[0]);
            end else if (w_hit && r_blink_type) begin
                r <= ~r_in;
                g <= ~g_in;
                b <= ~b_in;
            end else begin
                r <= r_in;
                g <= g_in;
                b <= b_in;
            end
        end
    end

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed-vector bench for cursor_overlay with hand-computed expected pixels.
module tb_cursor_overlay;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  register_adr = '0;
    logic [23:0] register_data = '0;
    logic        register_write = 1'b0;
    logic [8:0]  video_x = '0;
    logic [8:0]  video_y = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic [7:0]  r_in = 8'hAA, g_in = 8'hBB, b_in = 8'hCC;
    logic [7:0]  r, g, b;
    logic        hsync, vsync;

    int n_vec  = 0;
    int n_miss = 0;

    cursor_overlay #(.CURSOR_SIZE(16), .BLINK_UNIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .register_adr(register_adr), .register_data(register_data),
        .register_write(register_write),
        .video_x(video_x), .video_y(video_y),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %06h, expected %06h", tag, got, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [6:0] adr, input logic [23:0] data);
        register_adr   = adr;
        register_data  = data;
        register_write = 1'b1;
        tick_clk();
        register_write = 1'b0;
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] rgb);
        video_x = 9'(x);
        video_y = 9'(y);
        {r_in, g_in, b_in} = rgb;
        tick_clk();
    endtask

    task automatic vtick();
        vsync_in = 1'b1;
        tick_clk();
        vsync_in = 1'b0;
        tick_clk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("reset_rgb", {r, g, b}, 24'h000000);
        check("reset_syncs", {30'd0, hsync, vsync}, 32'd0);
        reset_n = 1'b1;

        // Pass-through, syncs delayed by one cycle
        hsync_in = 1'b1; vsync_in = 1'b0;
        pix(0, 0, 24'h123456);
        check("passthru", {r, g, b}, 24'h123456);
        check("sync_h", {30'd0, hsync, vsync}, 32'd2);
        hsync_in = 1'b0; vsync_in = 1'b1;
        pix(0, 0, 24'h123456);
        check("sync_v", {30'd0, hsync, vsync}, 32'd1);
        vsync_in = 1'b0;

        // Cursor at (10,20), rows = 8001, red intense
        for (int i = 0; i < 16; i++) reg_wr(7'h4f, 24'(i << 16) | 24'h008001);
        reg_wr(7'h4d, (24'd20 << 12) | 24'd10);
        reg_wr(7'h4e, 24'h800009);
        pix(10, 20, 24'h123456); check("hit_left",    {r, g, b}, 24'hFF0000);
        pix(25, 20, 24'h123456); check("hit_right",   {r, g, b}, 24'hFF0000);
        pix(10, 35, 24'h123456); check("hit_bottom",  {r, g, b}, 24'hFF0000);
        pix(11, 20, 24'h123456); check("pat_zero",    {r, g, b}, 24'h123456);
        pix(9, 20, 24'h123456);  check("left_out",    {r, g, b}, 24'h123456);
        pix(10, 36, 24'h123456); check("below_out",   {r, g, b}, 24'h123456);

        // Green+blue, no intensity
        reg_wr(7'h4e, 24'h800006);
        pix(10, 20, 24'h123456); check("col_gb_half", {r, g, b}, 24'h008080);

        // Near right edge, all-ones pattern: no wrap to column 0
        for (int i = 0; i < 16; i++) reg_wr(7'h4f, 24'(i << 16) | 24'h00FFFF);
        reg_wr(7'h4d, (24'd250 << 12) | 24'd500);
        reg_wr(7'h4e, 24'h800009);
        pix(500, 250, 24'h123456); check("edge_500", {r, g, b}, 24'hFF0000);
        pix(511, 250, 24'h123456); check("edge_511", {r, g, b}, 24'hFF0000);
        pix(511, 265, 24'h123456); check("edge_511_row15", {r, g, b}, 24'hFF0000);
        for (int x = 0; x < 4; x++) begin
            pix(x, 250, 24'h123456);
            check($sformatf("nowrap_x%0d", x), {r, g, b}, 24'h123456);
        end

        // Blink: on=1 (4 fields), off=2 (8 fields), complement in OFF
        reg_wr(7'h4e, 24'hCA0009);
        video_x = 9'd500; video_y = 9'd250; {r_in, g_in, b_in} = 24'h0F0F0F;
        pix(500, 250, 24'h0F0F0F); check("blink_start", {r, g, b}, 24'hFF0000);
        for (int k = 1; k <= 16; k++) begin
            vtick();
            pix(500, 250, 24'h0F0F0F);
            check($sformatf("blink_t%0d", k), {r, g, b},
                  ((k < 4) || (k >= 12 && k < 16)) ? 24'hFF0000 : 24'hF0F0F0);
        end
        reg_wr(7'h4e, 24'hCA0009);
        pix(500, 250, 24'h0F0F0F); check("blink_rewrite_on", {r, g, b}, 24'hFF0000);

        // Async reset while the cursor is shown
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {r, g, b}, 24'h000000);
        #3;
        reset_n = 1'b1;
        tick_clk();
        pix(500, 250, 24'h0F0F0F); check("post_reset_disabled", {r, g, b}, 24'h0F0F0F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
